// File: rtl/intc_sched_if.sv
// Bus interface for the intc_sched register window: byte address, lane
// enables, write data and combinational read data.
interface intc_sched_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/intc_sched.sv
// intc_sched: memory-mapped interrupt controller feeding CP0 HWInt.
// Edge/level request latching, software mask, registered irq/hwint and a
// post-acknowledge hold-off window.
// Optional build macro INTC_PRIORITY_EN: hwint shows only the lowest-index
// effective source (one-hot) instead of every effective source.
module intc_sched #(
  parameter int unsigned NSRC      = 6,
  parameter logic [31:0] BASE      = 32'h7f40,
  parameter logic [5:0]  EDGE_MASK = 6'b000100,
  parameter logic [5:0]  MASK_RST  = 6'b111111,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  intc_sched_if.slave     bus,
  output logic            irq,
  output logic [NSRC-1:0] hwint
);

  localparam logic [NSRC-1:0] EDGE      = EDGE_MASK[NSRC-1:0];
  localparam logic [3:0]      HOLD_INIT = (HOLDOFF == 0) ? 4'd0 : 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [NSRC-1:0] prev_src;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] eff;
  logic [NSRC-1:0] view;
  logic [NSRC-1:0] ack_clr;
  logic [31:0]     lane;
  logic [31:0]     word_off;
  logic [31:0]     cur;
  logic [1:0]      sel;
  logic            hit;
  logic            mask_wr;
  logic            ack_wr;
  logic            ack_any;
  logic            found;

  // Address decode, lane expansion and write strobes.
  always_comb begin
    lane     = {{8{bus.byteen[3]}}, {8{bus.byteen[2]}}, {8{bus.byteen[1]}}, {8{bus.byteen[0]}}};
    word_off = (bus.addr & ~32'h3) - BASE;
    hit      = (word_off[31:4] == '0);
    sel      = word_off[3:2];
    mask_wr  = hit && (bus.byteen != '0) && (sel == 2'd1);
    ack_wr   = hit && (bus.byteen != '0) && (sel == 2'd2);
    ack_any  = ack_wr && ((bus.wdata & lane) != '0);
    ack_clr  = ack_wr ? (bus.wdata[NSRC-1:0] & lane[NSRC-1:0] & EDGE) : '0;
  end

  // Pending view: a rising edge counts as pending in the cycle it appears,
  // which gives the single-cycle src -> irq latency; level sources pass through.
  always_comb begin
    rise = src & ~prev_src & EDGE;
    pend = ((pend_q | rise) & EDGE) | (src & ~EDGE);
    eff  = pend & mask;
`ifdef INTC_PRIORITY_EN
    view = eff & (-eff);
`else
    view = eff;
`endif
  end

  // Lowest effective index for CUR; bit 31 flags "nothing effective".
  always_comb begin
    cur   = 32'h8000_0000;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eff[i] && !found) begin
        cur   = i;
        found = 1'b1;
      end
    end
  end

  // Combinational register read.
  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (sel)
        2'd0:    bus.rdata = 32'(pend);
        2'd1:    bus.rdata = 32'(mask);
        2'd2:    bus.rdata = '0;
        default: bus.rdata = cur;
      endcase
    end
  end

  // Edge latches and mask register; a new edge beats a same-cycle ACK clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_src <= '0;
      pend_q   <= '0;
      mask     <= MASK_RST[NSRC-1:0];
    end else begin
      prev_src <= src;
      pend_q   <= (pend_q & ~ack_clr) | rise;
      if (mask_wr)
        mask <= (mask & ~lane[NSRC-1:0]) | (bus.wdata[NSRC-1:0] & lane[NSRC-1:0]);
    end
  end

  // Request FSM with registered irq/hwint and hold-off countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      irq   <= 1'b0;
      hwint <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eff != '0) begin
            state <= ACTIVE;
            irq   <= 1'b1;
            hwint <= view;
          end else begin
            irq   <= 1'b0;
            hwint <= '0;
          end
        end
        ACTIVE: begin
          if (ack_any) begin
            irq   <= 1'b0;
            hwint <= '0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_INIT;
            end
          end else if (eff == '0) begin
            state <= IDLE;
            irq   <= 1'b0;
            hwint <= '0;
          end else begin
            irq   <= 1'b1;
            hwint <= view;
          end
        end
        HOLD: begin
          irq   <= 1'b0;
          hwint <= '0;
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          hwint <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_sched.sv
// Self-checking bench for intc_sched: a cycle-level model (pending/mask
// rules plus a hold-off time window) is compared every negedge, and
// directed scenarios carry literal expectations.
module tb_intc_sched;

  localparam logic [5:0]  EDGE    = 6'b000100;
  localparam logic [31:0] BASE    = 32'h7f40;
  localparam int          HOLDOFF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] src = '0;
  logic       irq;
  logic [5:0] hwint;

  intc_sched_if bus();

  intc_sched #(.NSRC(6), .BASE(32'h7f40), .EDGE_MASK(6'b000100),
               .MASK_RST(6'b111111), .HOLDOFF(4)) dut (
    .clk(clk), .reset(rst_n), .src(src), .bus(bus), .irq(irq), .hwint(hwint)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [5:0] m_pe = '0, m_prev = '0, m_mask = 6'h3f, m_hw = '0;
  logic       m_irq = 1'b0;
  int         m_cycle = 0, m_block = -1;
  logic [5:0] mv_pend, mv_eff;
  logic       mv_wr, mv_ack;
  logic [31:0] mv_lane;
  int          mv_off;

  function automatic logic [5:0] m_pend(input logic [5:0] s);
    logic [5:0] p;
    for (int i = 0; i < 6; i++)
      p[i] = EDGE[i] ? (m_pe[i] | (s[i] & ~m_prev[i])) : s[i];
    return p;
  endfunction

  function automatic logic [5:0] m_view(input logic [5:0] e);
`ifdef INTC_PRIORITY_EN
    for (int i = 0; i < 6; i++)
      if (e[i]) return 6'(1 << i);
    return '0;
`else
    return e;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [5:0] s);
    logic [5:0] e;
    if (a < BASE || a > BASE + 32'd15) return '0;
    e = m_pend(s) & m_mask;
    case ((a - BASE) >> 2)
      0: return {26'd0, m_pend(s)};
      1: return {26'd0, m_mask};
      2: return '0;
      default: begin
        for (int i = 0; i < 6; i++)
          if (e[i]) return i;
        return 32'h8000_0000;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pe = '0; m_prev = '0; m_mask = 6'h3f; m_hw = '0; m_irq = 1'b0;
      m_cycle = 0; m_block = -1;
    end else begin
      m_cycle++;
      mv_pend = m_pend(src);
      mv_eff  = mv_pend & m_mask;
      mv_wr   = (bus.addr >= BASE) && (bus.addr <= BASE + 32'd15) && (bus.byteen != 0);
      mv_off  = int'((bus.addr - BASE) >> 2);
      mv_lane = '0;
      for (int b = 0; b < 4; b++)
        if (bus.byteen[b]) mv_lane[b*8 +: 8] = 8'hff;
      mv_ack  = mv_wr && mv_off == 2 && ((bus.wdata & mv_lane) != 0);
      // outputs: silent through edge (ack + HOLDOFF), else follow eff
      if (m_cycle <= m_block) begin
        m_irq = 1'b0; m_hw = '0;
      end else if (m_irq && mv_ack) begin
        m_block = m_cycle + HOLDOFF;
        m_irq = 1'b0; m_hw = '0;
      end else begin
        m_irq = (mv_eff != 0);
        m_hw  = m_view(mv_eff);
      end
      // pending bits: new edge wins over a clear
      for (int i = 0; i < 6; i++) begin
        if (EDGE[i] && src[i] && !m_prev[i]) m_pe[i] = 1'b1;
        else if (mv_wr && mv_off == 2 && bus.byteen[0] && bus.wdata[i]) m_pe[i] = 1'b0;
      end
      m_prev = src;
      if (mv_wr && mv_off == 1 && bus.byteen[0]) m_mask = bus.wdata[5:0];
    end
  end

  // Compare process
  always @(negedge clk) begin
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("hwint", {26'd0, hwint}, {26'd0, m_hw});
    chk("rdata", bus.rdata, m_read(bus.addr, src));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr = a; bus.wdata = d; bus.byteen = be;
    step();
    bus.byteen = '0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a; #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic pulse(input logic [5:0] s);
    src = s; step(); src = '0;
  endtask

  task automatic wait_irq(input string name, input int exp_n);
    int n = 0;
    while (!irq && n < 12) begin step(); n++; end
    chk(name, n, exp_n);
  endtask

  initial begin
    bus.addr = '0; bus.byteen = '0; bus.wdata = '0;
    // 1: reset
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_hwint", {26'd0, hwint}, 0);
    rd("rst_mask", 32'h7f44, 32'h3f);
    rd("rst_pend", 32'h7f40, 32'h0);

    // 2: edge request, CUR, ack and hold-off
    pulse(6'b000100);
    chk("edge_irq", {31'd0, irq}, 1);
    chk("edge_hwint", {26'd0, hwint}, 32'h4);
    rd("cur", 32'h7f4c, 32'd2);
    bus_wr(32'h7f48, 32'h4, 4'hf);
    for (int k = 0; k < 4; k++) begin
      chk("hold_low", {31'd0, irq}, 0);
      step();
    end
    rd("pend_cleared", 32'h7f40, 32'h0);
    rd("cur_empty", 32'h7f4c, 32'h8000_0000);

    // 3: masked edge, then unmask
    bus_wr(32'h7f44, 32'h0, 4'hf);
    pulse(6'b000100);
    rd("masked_pend", 32'h7f40, 32'h4);
    chk("masked_irq", {31'd0, irq}, 0);
    bus_wr(32'h7f44, 32'h3f, 4'hf);
    chk("unmask_lat0", {31'd0, irq}, 0);
    step();
    chk("unmask_irq", {31'd0, irq}, 1);

    // 4: edge during HOLD, then edge + ACK in the same cycle
    bus_wr(32'h7f48, 32'h4, 4'hf);
    pulse(6'b000100);
    wait_irq("reentry_after_hold", 4);
    src = 6'b000100;
    bus_wr(32'h7f48, 32'h4, 4'hf);
    src = '0;
    rd("set_wins", 32'h7f40, 32'h4);
    wait_irq("reentry2", 5);
    bus_wr(32'h7f48, 32'h4, 4'hf);
    repeat (6) step();
    rd("pend_idle", 32'h7f40, 32'h0);

    // 5: level sources
    src = 6'b001001;
    step();
    chk("level_irq", {31'd0, irq}, 1);
`ifdef INTC_PRIORITY_EN
    chk("level_hwint", {26'd0, hwint}, 32'h01);
`else
    chk("level_hwint", {26'd0, hwint}, 32'h09);
`endif
    src = 6'b001000;
    step();
    chk("level_drop", {26'd0, hwint}, 32'h08);
    bus_wr(32'h7f48, 32'h0, 4'hf);
    chk("ack_zero", {31'd0, irq}, 1);
    src = '0;
    step(); step();
    chk("level_gone", {31'd0, irq}, 0);
    bus_wr(32'h7f44, 32'h0, 4'b1110);
    rd("lane_off", 32'h7f44, 32'h3f);
    bus_wr(32'h7f40, 32'h3f, 4'hf);
    rd("pend_ro", 32'h7f40, 32'h0);
    rd("ack_reads0", 32'h7f48, 32'h0);
    rd("outside", 32'h7f50, 32'h0);

    // 6: reset mid-ACTIVE and mid-HOLD
    bus_wr(32'h7f44, 32'h4, 4'hf);
    pulse(6'b000100);
    chk("pre_rst_irq", {31'd0, irq}, 1);
    rst_n = 1'b0; #1;
    chk("rstA_irq", {31'd0, irq}, 0);
    chk("rstA_hwint", {26'd0, hwint}, 0);
    rd("rstA_pend", 32'h7f40, 32'h0);
    rd("rstA_mask", 32'h7f44, 32'h3f);
    step();
    rst_n = 1'b1;
    pulse(6'b000100);
    bus_wr(32'h7f48, 32'h4, 4'hf);
    step();
    rst_n = 1'b0; #1;
    chk("rstH_irq", {31'd0, irq}, 0);
    rd("rstH_pend", 32'h7f40, 32'h0);
    step();
    rst_n = 1'b1;
    pulse(6'b000100);
    chk("post_rst_irq", {31'd0, irq}, 1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
